// File: rtl/xain_pkg.sv
// Shared defaults and state encoding for the ioctl ROM download router.
package xain_pkg;

    localparam int NUM_BRAM_DEF = 6;
    localparam int BRAM_AW_DEF  = 20;

    // Region 0 sits in the least significant BRAM_AW bits.
    localparam logic [NUM_BRAM_DEF*BRAM_AW_DEF-1:0] BRAM_SIZES_DEF = {
        20'h08000, 20'h20000, 20'h10000, 20'h08000, 20'h08000, 20'h04000
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SDR_REQ,
        ST_FLUSH,
        ST_DONE
    } router_state_t;

endpackage

// File: rtl/ioctl_region_decode.sv
// Maps a download byte offset onto the SDRAM window, one BRAM region or
// the out-of-range bucket past the last region.
module ioctl_region_decode
    import xain_pkg::*;
#(
    parameter int                          SDR_AW     = 25,
    parameter int unsigned                 SDR_BYTES  = 32'h0010_0000,
    parameter int                          BRAM_AW    = 20,
    parameter int                          NUM_BRAM   = NUM_BRAM_DEF,
    parameter logic [NUM_BRAM*BRAM_AW-1:0] BRAM_SIZES = BRAM_SIZES_DEF
) (
    input  logic [SDR_AW:0]      off,
    output logic                 is_sdr,
    output logic [NUM_BRAM-1:0]  region,
    output logic [BRAM_AW-1:0]   offset,
    output logic                 out_of_range
);

    // Wide enough that the running sum of all region sizes cannot wrap.
    localparam int CW = SDR_AW + BRAM_AW + 4;

    logic [CW-1:0] off_ext;
    logic [CW-1:0] base;
    logic [CW-1:0] lim;

    always_comb begin
        is_sdr       = 1'b0;
        region       = '0;
        offset       = '0;
        out_of_range = 1'b0;
        off_ext      = CW'(off);
        base         = CW'(SDR_BYTES);
        lim          = base;
        if (off_ext < base) begin
            is_sdr = 1'b1;
        end else begin
            out_of_range = 1'b1;
            for (int i = 0; i < NUM_BRAM; i++) begin
                lim = base + CW'(BRAM_SIZES[i*BRAM_AW +: BRAM_AW]);
                if (out_of_range && (off_ext < lim)) begin
                    region[i]    = 1'b1;
                    offset       = BRAM_AW'(off_ext - base);
                    out_of_range = 1'b0;
                end
                base = lim;
            end
        end
    end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the ioctl ROM download into SDRAM words and on-chip BRAM regions.
// Define ROUTER_CHECKSUM_EN to add the 16-bit running checksum output.
module ioctl_rom_router
    import xain_pkg::*;
#(
    parameter int                          SDR_AW     = 25,
    parameter int unsigned                 SDR_BYTES  = 32'h0010_0000,
    parameter int                          BRAM_AW    = 20,
    parameter int                          NUM_BRAM   = NUM_BRAM_DEF,
    parameter logic [NUM_BRAM*BRAM_AW-1:0] BRAM_SIZES = BRAM_SIZES_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_data,
    output logic                 ioctl_wait,
    output logic [SDR_AW-1:0]    sdr_addr,
    output logic [15:0]          sdr_data,
    output logic [1:0]           sdr_be,
    output logic                 sdr_req,
    input  logic                 sdr_rdy,
    output logic [BRAM_AW-1:0]   bram_addr,
    output logic [7:0]           bram_data,
    output logic [NUM_BRAM-1:0]  bram_cs,
    output logic                 bram_wr,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
`ifdef ROUTER_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam logic [SDR_AW:0] OFF_ONE = {{SDR_AW{1'b0}}, 1'b1};
    localparam logic [SDR_AW:0] OFF_MAX = '1;

    router_state_t state, state_next;

    logic [SDR_AW:0]     off;
    logic                dl_q, dl_rise;
    logic                restart, lo_pending;
    logic                skid_full;
    logic [7:0]          skid_data, take_byte;
    logic                take, skid_load, skid_drop, lost, start;
    logic                dec_sdr, dec_oor;
    logic [NUM_BRAM-1:0] dec_region;
    logic [BRAM_AW-1:0]  dec_offset;

    ioctl_region_decode #(
        .SDR_AW     (SDR_AW),
        .SDR_BYTES  (SDR_BYTES),
        .BRAM_AW    (BRAM_AW),
        .NUM_BRAM   (NUM_BRAM),
        .BRAM_SIZES (BRAM_SIZES)
    ) u_decode (
        .off          (off),
        .is_sdr       (dec_sdr),
        .region       (dec_region),
        .offset       (dec_offset),
        .out_of_range (dec_oor)
    );

    assign dl_rise    = ioctl_download & ~dl_q;
    assign sdr_req    = (state == ST_SDR_REQ);
    assign ioctl_wait = (state == ST_SDR_REQ) || (state == ST_FLUSH) || skid_full;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= ST_IDLE;
        else       state <= state_next;
    end

    // A held skid byte always wins over the live strobe, so bytes stay in order.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        take_byte  = ioctl_data;
        skid_load  = 1'b0;
        skid_drop  = 1'b0;
        lost       = 1'b0;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dl_rise) begin
                    start      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dl_rise) begin
                    start = 1'b1;
                end else if (skid_full) begin
                    take      = 1'b1;
                    take_byte = skid_data;
                    skid_drop = 1'b1;
                    lost      = ioctl_wr;
                end else if (ioctl_download) begin
                    take = ioctl_wr;
                end else if (lo_pending) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_DONE;
                end
                if (take && dec_sdr && off[0]) state_next = ST_SDR_REQ;
            end
            ST_SDR_REQ, ST_FLUSH: begin
                if (ioctl_wr) begin
                    if (skid_full) lost      = 1'b1;
                    else           skid_load = 1'b1;
                end
                if (state == ST_FLUSH) begin
                    state_next = ST_SDR_REQ;
                end else if (sdr_rdy) begin
                    if (restart || dl_rise) begin
                        start      = 1'b1;
                        state_next = ST_RUN;
                    end else if (ioctl_download || skid_full || skid_load) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (dl_rise) begin
                    start      = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dl_q       <= 1'b0;
            off        <= '0;
            restart    <= 1'b0;
            lo_pending <= 1'b0;
            skid_full  <= 1'b0;
            skid_data  <= 8'h00;
            overflow   <= 1'b0;
            sdr_addr   <= '0;
            sdr_data   <= 16'h0000;
            sdr_be     <= 2'b00;
            bram_addr  <= '0;
            bram_data  <= 8'h00;
            bram_cs    <= '0;
            bram_wr    <= 1'b0;
`ifdef ROUTER_CHECKSUM_EN
            checksum   <= 16'h0000;
`endif
        end else begin
            dl_q    <= ioctl_download;
            bram_wr <= 1'b0;
            bram_cs <= '0;
            if (start) begin
                off        <= '0;
                restart    <= 1'b0;
                lo_pending <= 1'b0;
                skid_full  <= 1'b0;
                overflow   <= 1'b0;
`ifdef ROUTER_CHECKSUM_EN
                checksum   <= 16'h0000;
`endif
            end else begin
                if (dl_rise && ((state == ST_SDR_REQ) || (state == ST_FLUSH)))
                    restart <= 1'b1;
                if (skid_load) begin
                    skid_full <= 1'b1;
                    skid_data <= ioctl_data;
                end else if (skid_drop) begin
                    skid_full <= 1'b0;
                end
                if (lost) overflow <= 1'b1;
                // Odd-length tail: write the lone low byte with only its enable set.
                if (state == ST_FLUSH) begin
                    sdr_data[15:8] <= 8'h00;
                    sdr_be         <= 2'b01;
                    sdr_addr       <= {off[SDR_AW-1:1], 1'b0};
                    lo_pending     <= 1'b0;
                end
                if (take) begin
                    if (off != OFF_MAX) off <= off + OFF_ONE;
`ifdef ROUTER_CHECKSUM_EN
                    checksum <= checksum + {8'h00, take_byte};
`endif
                    if (dec_sdr) begin
                        if (!off[0]) begin
                            sdr_data[7:0] <= take_byte;
                            lo_pending    <= 1'b1;
                        end else begin
                            sdr_data[15:8] <= take_byte;
                            sdr_be         <= 2'b11;
                            sdr_addr       <= {off[SDR_AW-1:1], 1'b0};
                            lo_pending     <= 1'b0;
                        end
                    end else if (dec_oor) begin
                        overflow <= 1'b1;
                    end else begin
                        bram_wr   <= 1'b1;
                        bram_cs   <= dec_region;
                        bram_addr <= dec_offset;
                        bram_data <= take_byte;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router with a 4-byte SDRAM window and BRAM regions {4,2}.
module tb_ioctl_rom_router;

    localparam int                          SDR_AW     = 8;
    localparam int unsigned                 SDR_BYTES  = 4;
    localparam int                          BRAM_AW    = 8;
    localparam int                          NUM_BRAM   = 2;
    localparam logic [NUM_BRAM*BRAM_AW-1:0] BRAM_SIZES = {8'd2, 8'd4};

    logic                CLK;
    logic                RSTn;
    logic                ioctl_download;
    logic                ioctl_wr;
    logic [7:0]          ioctl_data;
    logic                ioctl_wait;
    logic [SDR_AW-1:0]   sdr_addr;
    logic [15:0]         sdr_data;
    logic [1:0]          sdr_be;
    logic                sdr_req;
    logic                sdr_rdy;
    logic [BRAM_AW-1:0]  bram_addr;
    logic [7:0]          bram_data;
    logic [NUM_BRAM-1:0] bram_cs;
    logic                bram_wr;
    logic                busy;
    logic                done;
    logic                overflow;
`ifdef ROUTER_CHECKSUM_EN
    logic [15:0]         checksum;
`endif

    int          total_cnt   = 0;
    int          bad_cnt     = 0;
    int          rdy_delay   = 2;
    int          done_cnt    = 0;
    int          wait_diff   = 0;
    int          wait_cycles = 0;
    logic [15:0] done_csum   = 16'h0000;
    logic [25:0] sdr_q[$];
    logic [17:0] bram_q[$];

    ioctl_rom_router #(
        .SDR_AW     (SDR_AW),
        .SDR_BYTES  (SDR_BYTES),
        .BRAM_AW    (BRAM_AW),
        .NUM_BRAM   (NUM_BRAM),
        .BRAM_SIZES (BRAM_SIZES)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .sdr_addr       (sdr_addr),
        .sdr_data       (sdr_data),
        .sdr_be         (sdr_be),
        .sdr_req        (sdr_req),
        .sdr_rdy        (sdr_rdy),
        .bram_addr      (bram_addr),
        .bram_data      (bram_data),
        .bram_cs        (bram_cs),
        .bram_wr        (bram_wr),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
`ifdef ROUTER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SDRAM model: acknowledges a request rdy_delay cycles after seeing it.
    initial begin : responder
        int req_cycles;
        req_cycles = 0;
        sdr_rdy = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (sdr_rdy) begin
                sdr_rdy    = 1'b0;
                req_cycles = 0;
            end else if (sdr_req) begin
                req_cycles++;
                if (req_cycles >= rdy_delay) begin
                    sdr_rdy = 1'b1;
                    sdr_q.push_back({sdr_addr, sdr_data, sdr_be});
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (bram_wr) bram_q.push_back({bram_cs, bram_addr, bram_data});
        if (done) begin
            done_cnt++;
`ifdef ROUTER_CHECKSUM_EN
            done_csum = checksum;
`endif
        end
        if (ioctl_wait != sdr_req) wait_diff++;
        if (ioctl_wait) wait_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] sdrAt(input int i);
        if (i < sdr_q.size()) return sdr_q[i];
        return '1;
    endfunction

    function automatic logic [17:0] bramAt(input int i);
        if (i < bram_q.size()) return bram_q[i];
        return '1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        for (int n = 0; n < 200 && ioctl_wait; n++) tick();
        if (ioctl_wait) checkOutput("wait_timeout", 32'(ioctl_wait), 32'd0);
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic pulseWr(input logic [7:0] b);
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic startDownload();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic endDownload(input string tag);
        int d0;
        d0 = done_cnt;
        ioctl_download = 1'b0;
        for (int n = 0; n < 300 && done_cnt == d0; n++) tick();
        tick();
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({ioctl_wait, sdr_req, bram_wr, busy, done, overflow}), 32'd0);
        checkOutput({tag, "_cs"}, 32'(bram_cs), 32'd0);
        checkOutput({tag, "_sdr"}, 32'({sdr_addr, sdr_data, sdr_be}), 32'd0);
        checkOutput({tag, "_bram"}, 32'({bram_addr, bram_data}), 32'd0);
    endtask

    initial begin : main
        int s0, b0, w0, wc0;
        logic [25:0] e;
        logic [17:0] be;

        RSTn = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_data = 8'h00;
        repeat (3) tick();
        checkAllZero("reset");
        RSTn = 1'b1;
        tick();

        // Two full SDRAM words; ioctl_wait must track sdr_req exactly.
        rdy_delay = 3;
        s0 = sdr_q.size();
        w0 = wait_diff;
        wc0 = wait_cycles;
        startDownload();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        endDownload("t1");
        checkOutput("t1_count", 32'(sdr_q.size() - s0), 32'd2);
        checkOutput("t1_wr0", 32'(sdrAt(s0)), 32'({8'h00, 16'h2211, 2'b11}));
        checkOutput("t1_wr1", 32'(sdrAt(s0 + 1)), 32'({8'h02, 16'h4433, 2'b11}));
        checkOutput("t1_wait_eq_req", 32'(wait_diff - w0), 32'd0);
        checkOutput("t1_wait_seen", 32'(wait_cycles != wc0), 32'd1);

        // Odd length: the third byte goes out as a flush with be=01.
        s0 = sdr_q.size();
        startDownload();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        endDownload("t2");
        checkOutput("t2_count", 32'(sdr_q.size() - s0), 32'd2);
        e = sdrAt(s0 + 1);
        checkOutput("t2_flush_addr", 32'(e[25:18]), 32'd2);
        checkOutput("t2_flush_lo", 32'(e[9:2]), 32'h33);
        checkOutput("t2_flush_be", 32'(e[1:0]), 32'b01);

        // Bytes past SDRAM fill region 0 then region 1; the 11th byte overflows.
        b0 = bram_q.size();
        startDownload();
        for (int i = 0; i < 10; i++) applyStimulus(8'hA0 + 8'(i));
        checkOutput("t3_ovf_pre", 32'(overflow), 32'd0);
        applyStimulus(8'hEE);
        checkOutput("t3_ovf", 32'(overflow), 32'd1);
        endDownload("t3");
        checkOutput("t3_bram_count", 32'(bram_q.size() - b0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            be = bramAt(b0 + i);
            checkOutput($sformatf("t3_bram%0d", i), 32'(be),
                        32'({(i < 4) ? 2'b01 : 2'b10, 8'((i < 4) ? i : i - 4), 8'hA4 + 8'(i)}));
        end
        checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Slow acknowledge: one byte parks in the skid, the next is lost.
        rdy_delay = 20;
        s0 = sdr_q.size();
        startDownload();
        checkOutput("t4_ovf_clear", 32'(overflow), 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        tick();
        tick();
        checkOutput("t4_wait", 32'(ioctl_wait), 32'd1);
        pulseWr(8'h03);
        checkOutput("t4_skid_no_ovf", 32'(overflow), 32'd0);
        tick();
        pulseWr(8'h04);
        checkOutput("t4_skid_ovf", 32'(overflow), 32'd1);
        applyStimulus(8'h05);
        endDownload("t4");
        checkOutput("t4_count", 32'(sdr_q.size() - s0), 32'd2);
        checkOutput("t4_wr0", 32'(sdrAt(s0)), 32'({8'h00, 16'h0201, 2'b11}));
        checkOutput("t4_wr1", 32'(sdrAt(s0 + 1)), 32'({8'h02, 16'h0503, 2'b11}));

        // Long stream 01..FF: most bytes are dropped but all are summed.
        rdy_delay = 1;
        s0 = sdr_q.size();
        b0 = bram_q.size();
        startDownload();
        for (int i = 1; i < 256; i++) applyStimulus(8'(i));
        endDownload("t5");
        checkOutput("t5_sdr_count", 32'(sdr_q.size() - s0), 32'd2);
        checkOutput("t5_bram_count", 32'(bram_q.size() - b0), 32'd6);
        checkOutput("t5_ovf", 32'(overflow), 32'd1);
`ifdef ROUTER_CHECKSUM_EN
        checkOutput("t5_checksum", 32'(done_csum), 32'h7F80);
`endif

        // Reset in the middle of an outstanding request.
        rdy_delay = 20;
        startDownload();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        tick();
        checkOutput("t6_req_up", 32'(sdr_req), 32'd1);
        RSTn = 1'b0;
        #1;
        checkAllZero("t6_async");
        ioctl_download = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        checkOutput("t6_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
